// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped table of tag/target/2-bit counter.
// Ports: clk/rstn; IF lookup (if_valid_i, if_pc_i, hold_i); flush_i;
//   EX resolution (ex_*_i); registered prediction (pred_*_o);
//   mispredict_o pulse; saturating statistics (br_cnt_o, miss_cnt_o).
module bpu #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              ex_upd_valid_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_taken_i,
    input  logic [ADDR_W-1:0] ex_target_i,
    input  logic              ex_pred_taken_i,
    input  logic [ADDR_W-1:0] ex_pred_target_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    output logic              mispredict_o,
    output logic [CNT_W-1:0]  br_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic              hit_q;
    logic              taken_q;
    logic [ADDR_W-1:0] ptgt_q;
    logic              mp_q;
    logic [CNT_W-1:0]  br_q;
    logic [CNT_W-1:0]  miss_q;

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_pc;
    assign unused_pc = ^{if_pc_i[1:0], ex_pc_i[1:0]};

    // Lookup side
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             l_taken;

    assign l_idx   = if_pc_i[IDX_W+1:2];
    assign l_tag   = if_pc_i[ADDR_W-1:IDX_W+2];
    assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_taken = l_hit && ctr_q[l_idx][1];

    // Update side
    logic [IDX_W-1:0]  e_idx;
    logic [TAG_W-1:0]  e_tag;
    logic              e_hit;
    logic              wr_en;
    logic [1:0]        ctr_d;
    logic [ADDR_W-1:0] tgt_d;
    logic              mp_d;

    assign e_idx = ex_pc_i[IDX_W+1:2];
    assign e_tag = ex_pc_i[ADDR_W-1:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    // A not-taken miss leaves the table alone; flush discards the write.
    assign wr_en = ex_upd_valid_i && !flush_i && (e_hit || ex_taken_i);

    always_comb begin
        ctr_d = 2'b10;
        tgt_d = ex_taken_i ? ex_target_i : tgt_q[e_idx];
        if (e_hit) begin
            if (ex_taken_i)
                ctr_d = (ctr_q[e_idx] == 2'b11) ? 2'b11
                                                : ctr_q[e_idx] + 2'd1;
            else
                ctr_d = (ctr_q[e_idx] == 2'b00) ? 2'b00
                                                : ctr_q[e_idx] - 2'd1;
        end
    end

    assign mp_d = ex_upd_valid_i &&
                  ((ex_taken_i != ex_pred_taken_i) ||
                   (ex_taken_i && ex_pred_taken_i &&
                    (ex_target_i != ex_pred_target_i)));

    // Table state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[e_idx] <= 1'b1;
            tag_q[e_idx]   <= e_tag;
            tgt_q[e_idx]   <= tgt_d;
            ctr_q[e_idx]   <= ctr_d;
        end
    end

    // Prediction registers aligned with IF/ID
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_q   <= 1'b0;
            taken_q <= 1'b0;
            ptgt_q  <= '0;
        end else if (!hold_i) begin
            hit_q   <= if_valid_i && l_hit;
            taken_q <= if_valid_i && l_taken;
            ptgt_q  <= (if_valid_i && l_taken) ? tgt_q[l_idx] : '0;
        end
    end

    // Mispredict pulse and saturating statistics
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mp_q   <= 1'b0;
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            mp_q <= mp_d;
            if (ex_upd_valid_i && !(&br_q))
                br_q <= br_q + 1'b1;
            if (mp_d && !(&miss_q))
                miss_q <= miss_q + 1'b1;
        end
    end

    assign pred_hit_o    = hit_q;
    assign pred_taken_o  = taken_q;
    assign pred_target_o = ptgt_q;
    assign mispredict_o  = mp_q;
    assign br_cnt_o      = br_q;
    assign miss_cnt_o    = miss_q;

endmodule

// File: tb/tb_bpu.sv
// Directed testbench for bpu (CNT_W=4 so counter saturation is reachable).
// Checks reset, allocation, training, aliasing, flush, hold, saturation.
module tb_bpu;

    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rstn;
    logic          if_valid_i;
    logic [AW-1:0] if_pc_i;
    logic          hold_i;
    logic          flush_i;
    logic          ex_upd_valid_i;
    logic [AW-1:0] ex_pc_i;
    logic          ex_taken_i;
    logic [AW-1:0] ex_target_i;
    logic          ex_pred_taken_i;
    logic [AW-1:0] ex_pred_target_i;
    logic          pred_hit_o;
    logic          pred_taken_o;
    logic [AW-1:0] pred_target_o;
    logic          mispredict_o;
    logic [CW-1:0] br_cnt_o;
    logic [CW-1:0] miss_cnt_o;

    int checks;
    int failures;
    int exp_br;
    int exp_miss;

    bpu #(.ADDR_W(AW), .ENTRIES(16), .CNT_W(CW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .hold_i           (hold_i),
        .flush_i          (flush_i),
        .ex_upd_valid_i   (ex_upd_valid_i),
        .ex_pc_i          (ex_pc_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .mispredict_o     (mispredict_o),
        .br_cnt_o         (br_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [AW-1:0] obs,
                       input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pred(input string tag, input logic h,
                            input logic t, input logic [AW-1:0] g);
        chk({tag, "_hit"}, {31'd0, pred_hit_o}, {31'd0, h});
        chk({tag, "_taken"}, {31'd0, pred_taken_o}, {31'd0, t});
        chk({tag, "_tgt"}, pred_target_o, g);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_br"}, {28'd0, br_cnt_o}, exp_br);
        chk({tag, "_miss"}, {28'd0, miss_cnt_o}, exp_miss);
    endtask

    task automatic lookup(input logic [AW-1:0] pc);
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        step();
        if_valid_i = 1'b0;
    endtask

    task automatic count(input logic mp);
        if (exp_br < 15) exp_br++;
        if (mp && exp_miss < 15) exp_miss++;
    endtask

    task automatic upd(input string tag, input logic [AW-1:0] pc,
                       input logic tk, input logic [AW-1:0] tg,
                       input logic ptk, input logic [AW-1:0] ptg,
                       input logic exp_mp);
        ex_upd_valid_i   = 1'b1;
        ex_pc_i          = pc;
        ex_taken_i       = tk;
        ex_target_i      = tg;
        ex_pred_taken_i  = ptk;
        ex_pred_target_i = ptg;
        step();
        ex_upd_valid_i = 1'b0;
        count(exp_mp);
        chk({tag, "_mp"}, {31'd0, mispredict_o}, {31'd0, exp_mp});
        chk_stats(tag);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_br = 0;
        exp_miss = 0;
        rstn = 1'b0;
        if_valid_i = 1'b0;
        if_pc_i = '0;
        hold_i = 1'b0;
        flush_i = 1'b0;
        ex_upd_valid_i = 1'b0;
        ex_pc_i = '0;
        ex_taken_i = 1'b0;
        ex_target_i = '0;
        ex_pred_taken_i = 1'b0;
        ex_pred_target_i = '0;
        #12;
        chk_pred("rst", 1'b0, 1'b0, 32'h0);
        chk("rst_mp", {31'd0, mispredict_o}, 32'd0);
        chk_stats("rst");
        rstn = 1'b1;
        step();

        lookup(32'h40);
        chk_pred("cold", 1'b0, 1'b0, 32'h0);

        upd("alloc", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        step();
        chk("mp_pulse_end", {31'd0, mispredict_o}, 32'd0);
        lookup(32'h40);
        chk_pred("alloc_lk", 1'b1, 1'b1, 32'h100);

        upd("nt1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
        upd("nt2", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup(32'h40);
        chk_pred("ctr0_lk", 1'b1, 1'b0, 32'h0);

        upd("tk1", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        lookup(32'h40);
        chk_pred("ctr1_lk", 1'b1, 1'b0, 32'h0);
        upd("tk2", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        lookup(32'h40);
        chk_pred("ctr2_lk", 1'b1, 1'b1, 32'h100);

        for (int i = 0; i < 4; i++)
            upd("sat", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        upd("dec3", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
        lookup(32'h40);
        chk_pred("ctrsat_lk", 1'b1, 1'b1, 32'h100);

        upd("tgtmis", 32'h40, 1'b1, 32'h104, 1'b1, 32'h100, 1'b1);
        lookup(32'h40);
        chk_pred("newtgt_lk", 1'b1, 1'b1, 32'h104);

        upd("alias", 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        lookup(32'h40);
        chk_pred("alias_old", 1'b0, 1'b0, 32'h0);
        lookup(32'h80);
        chk_pred("alias_new", 1'b1, 1'b1, 32'h200);

        flush_i = 1'b1;
        upd("flush", 32'hC4, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
        flush_i = 1'b0;
        lookup(32'hC4);
        chk_pred("flush_c4", 1'b0, 1'b0, 32'h0);
        lookup(32'h80);
        chk_pred("flush_80", 1'b0, 1'b0, 32'h0);

        if_valid_i = 1'b1;
        if_pc_i = 32'h80;
        upd("same", 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        chk_pred("nobypass", 1'b0, 1'b0, 32'h0);
        lookup(32'h80);
        chk_pred("after_same", 1'b1, 1'b1, 32'h300);

        hold_i = 1'b1;
        if_valid_i = 1'b1;
        if_pc_i = 32'h40;
        upd("hold_upd", 32'h40, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0);
        chk_pred("hold", 1'b1, 1'b1, 32'h300);
        if_valid_i = 1'b0;
        step();
        chk_pred("hold2", 1'b1, 1'b1, 32'h300);
        hold_i = 1'b0;
        lookup(32'h40);
        chk_pred("hold_tbl", 1'b1, 1'b1, 32'h400);
        step();
        chk_pred("novalid", 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 17; i++)
            upd("msat", 32'h1000, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1);
        chk("miss_sat", {28'd0, miss_cnt_o}, 32'd15);
        chk("br_sat", {28'd0, br_cnt_o}, 32'd15);

        ex_upd_valid_i = 1'b1;
        ex_pc_i = 32'h84;
        ex_taken_i = 1'b1;
        ex_target_i = 32'h600;
        ex_pred_taken_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        exp_br = 0;
        exp_miss = 0;
        chk_pred("arst", 1'b0, 1'b0, 32'h0);
        chk_stats("arst");
        step();
        ex_upd_valid_i = 1'b0;
        rstn = 1'b1;
        lookup(32'h84);
        chk_pred("arst_84", 1'b0, 1'b0, 32'h0);
        lookup(32'h40);
        chk_pred("arst_40", 1'b0, 1'b0, 32'h0);
        chk_stats("arst_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bpu.md
# bpu

Parametrised branch prediction unit for the Deilt_RISCV 5-stage pipeline, succeeding the fixed static predictor. It holds a direct-mapped table of ENTRIES branch records, each with a tag, a target and a 2-bit saturating counter. The table is looked up with the IF-stage PC, and the registered prediction lines up with the IF/ID register. EX-stage branch resolutions train the table and drive saturating branch and mispredict statistics counters.

## Interface
- ADDR_W, 32: instruction address width.
- ENTRIES, 16: table depth; power of 2, at least 2. IDX_W = log2(ENTRIES).
- CNT_W, 16: width of the statistics counters.
- clk  in  1  pipeline clock.
- rstn  in  1  reset; asynchronous, active-low.
- if_valid_i  in  1  IF PC valid, lookup request.
- if_pc_i  in  ADDR_W  IF-stage PC.
- hold_i  in  1  IF/ID stall; prediction outputs hold their value.
- flush_i  in  1  invalidate the whole table.
- ex_upd_valid_i  in  1  a branch or jump has resolved in EX.
- ex_pc_i  in  ADDR_W  PC of the resolved branch.
- ex_taken_i  in  1  actual direction.
- ex_target_i  in  ADDR_W  actual target.
- ex_pred_taken_i  in  1  prediction that accompanied this branch down the pipe.
- ex_pred_target_i  in  ADDR_W  predicted target that accompanied it.
- pred_hit_o  out  1  lookup hit a valid entry.
- pred_taken_o  out  1  predict taken.
- pred_target_o  out  ADDR_W  predicted target; 0 when pred_taken_o=0.
- mispredict_o  out  1  one-cycle pulse on a mispredicted resolution.
- br_cnt_o  out  CNT_W  resolved-branch count, saturating.
- miss_cnt_o  out  CNT_W  mispredict count, saturating.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2].
- Each entry stores valid, tag, target[ADDR_W] and ctr[1:0].
- Lookup (combinational read, registered result):
  - hit = valid && tag match; taken = hit && ctr[1].
  - Registered on a clk edge when !hold_i: with if_valid_i=1 the result is loaded; with if_valid_i=0 all three prediction outputs load 0.
- Update, when ex_upd_valid_i=1 and flush_i=0:
  - Hit: ctr increments if ex_taken_i, saturating at 3, else decrements, saturating at 0. When taken, target is overwritten with ex_target_i.
  - Miss and taken: the entry is allocated or replaced: valid=1, new tag, target=ex_target_i, ctr=2'b10.
  - Miss and not taken: no change.
- Mispredict = ex_upd_valid_i && ((ex_taken_i != ex_pred_taken_i) || (ex_taken_i && ex_pred_taken_i && ex_target_i != ex_pred_target_i)).
- Statistics:
  - br_cnt_o increments on every ex_upd_valid_i.
  - miss_cnt_o increments on every mispredict.
  - Both saturate at all-ones and never wrap.
  - Statistics update even when flush_i=1.
- flush_i clears every valid bit. flush_i has priority over a same-cycle update: the update is discarded, but still counted. Counters and targets in the table are not cleared by a flush.
- Same-index lookup and update in one cycle: the lookup sees the pre-update contents. There is no bypass.

## Timing
- Reset (rstn=0, asynchronous): all valid bits, ctr, targets and outputs are 0. Reset mid-operation discards any pending update.
- Lookup latency is 1 cycle: PC presented in cycle N gives a prediction on the outputs in cycle N+1.
- Update takes effect at the end of the cycle it is presented in. A lookup of the same PC in the next cycle sees the new state; its output appears one cycle later.
- mispredict_o is registered: it is high exactly in the cycle after the qualifying update, for 1 cycle.
- Counters are visible 1 cycle after the event.
- hold_i freezes only the prediction outputs. Table updates, flush and statistics still proceed during hold.

## Test plan
- Reset, then look up 0x0000_0040 -> pred_hit_o=0, pred_taken_o=0, pred_target_o=0; all counters 0.
- Update pc 0x40, taken, target 0x100, pred_taken=0 -> mispredict_o pulses the next cycle; miss_cnt_o=1, br_cnt_o=1. A lookup of 0x40 then gives hit=1, taken=1, target 0x100.
- Train pc 0x40 with not-taken twice (ctr 2->1->0) -> lookup gives hit=1, taken=0, target=0. Two taken updates then restore taken=1. Four consecutive taken updates keep ctr at 3.
- Alias: with pc 0x40 allocated, update pc 0x80 (same index 0, tag 2) taken, target 0x200 -> lookup 0x40 misses; lookup 0x80 hits with target 0x200.
- flush_i asserted in the same cycle as a taken update for pc 0xC4 -> no entry is allocated, all lookups miss afterwards, and br_cnt_o still increments.
- Hold and saturation: hold_i=1 while the PC changes -> the outputs keep their previous value. With CNT_W=4, 17 mispredicts -> miss_cnt_o=15.
